// File: rtl/fp16_result_packer.sv
// Packs converted FP16 results in pairs (FP32 words pass through), ORs per-word flags, buffers words in a small FIFO.
// Optional sticky fflags register for the CSR path is built only when FLAG_STICKY_EN is defined.
module fp16_result_packer #(
    parameter int OUT_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_result,
    input  logic        in_mode,
    input  logic [4:0]  in_flags,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_half,
    output logic        out_lane1_vld,
    output logic [4:0]  out_flags,
    input  logic        fflags_clr,
    output logic [4:0]  fflags
);

    localparam int PW = $clog2(OUT_DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW+1)'(OUT_DEPTH);

    typedef enum logic {EMPTY, HALF} state_t;

    typedef struct packed {
        logic [31:0] data;
        logic        half;
        logic        lane1_vld;
        logic [4:0]  flags;
    } entry_t;

    state_t      state, state_d;
    logic [15:0] lane0_data;
    logic [4:0]  lane0_flags;
    logic        flush_pend, flush_pend_d;

    entry_t      mem [OUT_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;

    logic   full, space, pop, push, want_write, accept, latch_lane0;
    entry_t push_word;

    assign full      = (count == DEPTH_CNT);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still takes a push.
    assign space     = !full || out_ready;

    always_comb begin
        want_write = 1'b0;
        push_word  = '0;
        case (state)
            EMPTY: begin
                if (in_valid && in_mode) begin
                    want_write = 1'b1;
                    push_word  = '{data: in_result, half: 1'b0, lane1_vld: 1'b0, flags: in_flags};
                end
            end
            HALF: begin
                if (in_valid && !in_mode) begin
                    want_write = 1'b1;
                    push_word  = '{data: {in_result[15:0], lane0_data}, half: 1'b1,
                                   lane1_vld: 1'b1, flags: lane0_flags | in_flags};
                end else if ((in_valid && in_mode) || flush || flush_pend) begin
                    want_write = 1'b1;
                    push_word  = '{data: {16'h0000, lane0_data}, half: 1'b1,
                                   lane1_vld: 1'b0, flags: lane0_flags};
                end
            end
            default: ;
        endcase
    end

    assign in_ready = !(want_write && !space) && !(state == HALF && in_valid && in_mode);
    assign accept   = in_valid && in_ready;
    assign push     = want_write && space;

    always_comb begin
        state_d     = state;
        latch_lane0 = 1'b0;
        case (state)
            EMPTY: begin
                if (accept && !in_mode) begin
                    state_d     = HALF;
                    latch_lane0 = 1'b1;
                end
            end
            HALF: begin
                if (push) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
        // A flush only matters while a lane is held after this cycle's input.
        flush_pend_d = (flush || flush_pend) && (state_d == HALF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            flush_pend  <= 1'b0;
            lane0_data  <= '0;
            lane0_flags <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            for (int unsigned i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
        end else begin
            state      <= state_d;
            flush_pend <= flush_pend_d;
            if (latch_lane0) begin
                lane0_data  <= in_result[15:0];
                lane0_flags <= in_flags;
            end
            if (push) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign {out_data, out_half, out_lane1_vld, out_flags} = mem[rd_ptr];

`ifdef FLAG_STICKY_EN
    logic [4:0] sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky <= '0;
        end else if (fflags_clr) begin
            sticky <= push ? push_word.flags : '0;
        end else if (push) begin
            sticky <= sticky | push_word.flags;
        end
    end

    assign fflags = sticky;
`else
    logic unused_clr;
    assign unused_clr = fflags_clr;
    assign fflags     = '0;
`endif

endmodule

// File: tb/tb_fp16_result_packer.sv
// Self-checking bench for fp16_result_packer: directed scenarios plus random traffic against a queue-based model.
module tb_fp16_result_packer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_mode, flush;
    logic        out_valid, out_ready, out_half, out_lane1_vld, fflags_clr;
    logic [31:0] in_result, out_data;
    logic [4:0]  in_flags, out_flags, fflags;

    always #5 clk = ~clk;

    fp16_result_packer #(.OUT_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_mode(in_mode), .in_flags(in_flags), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_half(out_half), .out_lane1_vld(out_lane1_vld), .out_flags(out_flags),
        .fflags_clr(fflags_clr), .fflags(fflags)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        half;
        logic        lane1;
        logic [4:0]  flags;
    } word_t;

    word_t       q[$];
    bit          m_half, m_fp, accepted;
    logic [15:0] m_data;
    logic [4:0]  m_flags, m_sticky;
    int          n_cmp, n_bad, n_steps;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock with the currently driven inputs; called just after a falling edge.
    task automatic step();
        bit    space, ww, rdy, pushed;
        word_t w;
        #1;
        accepted = 1'b0;
        if (rst) begin
            q.delete();
            m_half = 0; m_fp = 0; m_sticky = '0;
        end else begin
            space = (q.size() < DEPTH) || out_ready;
            ww    = (in_valid && (in_mode || m_half)) || (m_half && (flush || m_fp));
            rdy   = !(ww && !space) && !(m_half && in_valid && in_mode);
            check("in_ready", in_ready, rdy);
            check("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                check("out_data", out_data, q[0].data);
                check("out_half", out_half, q[0].half);
                check("out_lane1_vld", out_lane1_vld, q[0].lane1);
                check("out_flags", out_flags, q[0].flags);
            end
            check("fflags", fflags, m_sticky);
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            accepted = in_valid && rdy;
            pushed   = 1'b0;
            w        = '0;
            if (accepted) begin
                if (in_mode) begin
                    w = '{data: in_result, half: 1'b0, lane1: 1'b0, flags: in_flags};
                    pushed = 1'b1;
                end else if (m_half) begin
                    w = '{data: {in_result[15:0], m_data}, half: 1'b1, lane1: 1'b1,
                          flags: m_flags | in_flags};
                    pushed = 1'b1;
                    m_half = 0;
                end else begin
                    m_half = 1; m_data = in_result[15:0]; m_flags = in_flags;
                end
            end else if (m_half && space && ((in_valid && in_mode) || flush || m_fp)) begin
                w = '{data: {16'h0, m_data}, half: 1'b1, lane1: 1'b0, flags: m_flags};
                pushed = 1'b1;
                m_half = 0;
            end
            m_fp = (flush || m_fp) && m_half;
`ifdef FLAG_STICKY_EN
            if (fflags_clr) m_sticky = pushed ? w.flags : 5'b0;
            else if (pushed) m_sticky = m_sticky | w.flags;
`endif
            if (pushed) q.push_back(w);
        end
        n_steps++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(bit mode, logic [31:0] r, logic [4:0] f, bit fl);
        in_valid = 1'b1; in_mode = mode; in_result = r; in_flags = f; flush = fl;
        for (int i = 0; i < 20; i++) begin
            step();
            flush = 1'b0;
            if (accepted) break;
        end
        if (!accepted) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int s, n;
        n_cmp = 0; n_bad = 0; n_steps = 0;
        rst = 1; in_valid = 0; in_mode = 0; in_result = '0; in_flags = '0;
        flush = 0; out_ready = 1; fflags_clr = 0;
        @(negedge clk);
        idle(2);
        rst = 0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_fflags", fflags, 0);
        idle(1);

        // FP16 pair
        send(0, 32'h0000_3C00, 5'b0, 0);
        send(0, 32'h0000_4000, 5'b0, 0);
        check("pair_data", out_data, 32'h4000_3C00);
        check("pair_lane1", out_lane1_vld, 1);
        idle(2);

        // FP32 back-to-back
        s = n_steps;
        for (int i = 0; i < 8; i++) send(1, 32'h3F80_0000, 5'b0, 0);
        check("b2b_cycles", n_steps - s, 8);
        idle(2);

        // Mode switch leaves a partial word, then the FP32 word
        send(0, 32'h0000_7BFF, 5'b00101, 0);
        s = n_steps;
        send(1, 32'h1234_5678, 5'b0, 0);
        check("switch_cycles", n_steps - s, 2);
        idle(3);

        // Flush of a single element, then flush coinciding with a pair completion
        send(0, 32'h0000_3555, 5'b0, 0);
        flush = 1; step(); flush = 0;
        check("flush_data", out_data, 32'h0000_3555);
        check("flush_lane1", out_lane1_vld, 0);
        idle(2);
        send(0, 32'h0000_1111, 5'b0, 0);
        send(0, 32'h0000_2222, 5'b0, 1);
        idle(3);

        // Backpressure fill
        out_ready = 0; n = 0;
        in_valid = 1; in_mode = 1; in_result = 32'hA000_0000; in_flags = 5'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (accepted) begin n++; in_result = in_result + 1; end
        end
        check("fill_count", n, DEPTH);
        in_valid = 0; out_ready = 1;
        idle(4);

`ifdef FLAG_STICKY_EN
        fflags_clr = 1; step(); fflags_clr = 0;
        send(1, 32'h0000_0001, 5'b10000, 0);
        send(1, 32'h0000_0002, 5'b00010, 0);
        idle(2);
        check("sticky_or", fflags, 5'b10010);
        fflags_clr = 1; step(); fflags_clr = 0;
        check("sticky_clr", fflags, 5'b0);
`endif

        // Reset while a lane is held
        send(0, 32'h0000_ABCD, 5'b00001, 0);
        rst = 1; step(); rst = 0;
        check("hrst_valid", out_valid, 0);
        check("hrst_data", out_data, 0);
        check("hrst_half", out_half, 0);
        check("hrst_lane1", out_lane1_vld, 0);
        check("hrst_flags", out_flags, 0);
        check("hrst_fflags", fflags, 0);
        idle(3);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (!in_valid || accepted) begin
                in_valid  = ($urandom_range(0, 99) < 60);
                in_mode   = ($urandom_range(0, 99) < 35);
                in_result = $urandom;
                in_flags  = 5'($urandom);
            end
            flush      = ($urandom_range(0, 99) < 10);
            out_ready  = ($urandom_range(0, 99) < 70);
            fflags_clr = ($urandom_range(0, 99) < 5);
            step();
        end
        in_valid = 0; flush = 0; fflags_clr = 0; out_ready = 1;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fp16_result_packer.md
# fp16_result_packer

Output stage directly downstream of the FP32→FP16 result converter in the MAC datapath. Accepts one converted result per cycle over a valid/ready handshake. In FP16 mode it packs two consecutive half-precision results into one 32-bit word; in FP32 mode it passes words through unchanged. It ORs the IEEE exception flags of every element in a word, buffers packed words in a small output FIFO, and optionally keeps a sticky fflags register for the CSR path.

## Interface
- `OUT_DEPTH`, default 2: output FIFO entries; power of two, ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream result valid.
- `in_ready`  out  1  block accepts the result this cycle.
- `in_result`  in  32  converter output; FP16 value in [15:0] when `in_mode`=0.
- `in_mode`  in  1  0 = FP16 element, 1 = FP32 word (converter passthrough).
- `in_flags`  in  5  {NV,DZ,OF,UF,NX} from the converter.
- `flush`  in  1  single-cycle request to emit a half-filled pair.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  downstream accepts the head.
- `out_data`  out  32  packed word.
- `out_half`  out  1  word holds FP16 lanes.
- `out_lane1_vld`  out  1  upper lane holds a real element; 0 for a partial or FP32 word.
- `out_flags`  out  5  OR of the flags of the contributing elements.
- `fflags_clr`  in  1  clear the sticky flags (FLAG_STICKY_EN only).
- `fflags`  out  5  sticky accumulated flags (FLAG_STICKY_EN only).

## Operation
- Packer FSM has two states:
  - EMPTY: no lane held.
  - HALF: lane0 register holds one FP16 element and its flags.
- EMPTY, accepted FP16 element: latch `in_result[15:0]` and `in_flags` into lane0 → HALF. Nothing is written to the FIFO.
- EMPTY, accepted FP32 word: write {in_result, half=0, lane1_vld=0, in_flags} to the FIFO; stay EMPTY.
- HALF, accepted FP16 element: write {in_result[15:0], lane0} (lane1 in [31:16]), half=1, lane1_vld=1, flags = lane0 flags | in_flags → EMPTY.
- HALF with an FP32 word at the input (mode switch):
  - The input is not accepted that cycle (`in_ready`=0).
  - The partial word {16'h0, lane0}, half=1, lane1_vld=0 is written when the FIFO has space → EMPTY.
  - The FP32 word is accepted the following cycle at the earliest.
- Flush:
  - A `flush` pulse sets `flush_pend`.
  - While `flush_pend` is set in HALF with no same-cycle FP16 completion, the partial word is written when space allows → EMPTY.
  - `flush_pend` clears when the state after that cycle's input is EMPTY.
  - Flush with an accepted FP16 input in the same cycle is evaluated after the input: EMPTY+input+flush emits that element as a partial on the next write opportunity; HALF+input+flush completes the pair and then clears.
- `in_ready` = !(FIFO full and this cycle would write) && !(state==HALF && in_valid && in_mode).
  - `in_ready` may depend combinationally on `in_valid` and `in_mode`.
  - Upstream must not make `in_valid` depend on `in_ready`.
  - Once asserted, `in_valid`, `in_result`, `in_mode` and `in_flags` are held until accepted.
- FIFO:
  - Simultaneous push and pop when full is allowed; the pop frees the slot in the same cycle.
  - Pointers wrap modulo OUT_DEPTH.
  - Occupancy counter is log2(OUT_DEPTH)+1 bits.
- Reset clears the FSM to EMPTY, clears `flush_pend`, the FIFO and `fflags`, and discards any held lane0 without emitting it.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_half`=0, `out_lane1_vld`=0, `out_flags`=0, `fflags`=0. `in_ready` returns to 1 the cycle after reset deasserts.
- FP32 word accepted in cycle N → `out_valid` in cycle N+1 if the FIFO was empty.
- Second FP16 element accepted in cycle N → packed word valid in cycle N+1.
- Partial word (flush or mode switch) is written in the cycle the condition is seen with space available → valid at +1.
- Throughput: one FP32 word per cycle, or one FP16 element per cycle, with `out_ready` held at 1.
- Outputs are driven from FIFO registers; there is no combinational path from `in_*` to `out_*`.

## Configuration
- `FLAG_STICKY_EN` defined:
  - `fflags` |= `out_flags` of each word at FIFO push.
  - `fflags_clr` zeroes it; if clear and push happen in the same cycle, the result is the pushed flags only.
- `FLAG_STICKY_EN` undefined: `fflags` is tied to 0, `fflags_clr` is ignored, and no register is inferred.

## Test plan
- Input FP16 3C00 then 4000, flags 0 → one word 0x40003C00, half=1, lane1_vld=1, flags 0, valid one cycle after the second accept.
- Input FP32 3F800000 back-to-back for 8 cycles, out_ready=1 → eight outputs, in_ready always 1, latency 1.
- Input FP16 7BFF with OF|NX, then FP32 0x12345678 → partial 0x00007BFF (lane1_vld=0, flags OF|NX); in_ready low one cycle; FP32 word follows.
- Input one FP16 3555 then a flush pulse → 0x00003555, lane1_vld=0. Next, a flush in the same cycle as the second element of a pair → a single full word only.
- Hold out_ready=0 and stream FP32 words → exactly OUT_DEPTH accepted, then in_ready=0; release → order preserved, no loss.
- With FLAG_STICKY_EN, push NV then UF words → fflags=NV|UF; fflags_clr → 0. Assert rst while in HALF → no output emitted, all outputs 0.
